// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-ROM port arbiter.
//   ROM_SIZE_DEF - default ROM depth in words
//   state_t      - debug burst reader states
//   idx_oor()    - word-index range check for a byte address (index = a[30:2])
package imem_pkg;

    localparam int unsigned ROM_SIZE_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_t;

    // True when the word index of byte address a falls outside a ROM of 'size' words.
    function automatic logic idx_oor(input logic [30:0] a, input int unsigned size);
        return {3'b000, a[30:2]} >= size;
    endfunction

endpackage

// File: rtl/imem_dump_arbiter.sv
// imem_dump_arbiter: shares the combinational instruction-ROM read port between
// the CPU fetch path (priority) and a debug burst reader that streams ROM words
// out over a valid/ready link. A starvation counter forces one debug slot after
// MAX_WAIT consecutive denied cycles, stalling the CPU for that one cycle.
// Ports:
//   clk, reset (async, active-low)
//   f_req/f_addr/f_data/f_stall - CPU fetch side (zero-latency)
//   d_start/d_base/d_len        - burst command (sampled in IDLE only)
//   d_busy/d_data/d_valid/d_ready/d_done/d_err - burst stream and status
//   mem_addr/mem_data           - ROM port (combinational ROM)
module imem_dump_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ROM_SIZE = ROM_SIZE_DEF,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned LEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [30:0]      f_addr,
    output logic [31:0]      f_data,
    output logic             f_stall,
    input  logic             d_start,
    input  logic [30:0]      d_base,
    input  logic [LEN_W-1:0] d_len,
    output logic             d_busy,
    output logic [31:0]      d_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic             d_done,
    output logic             d_err,
    output logic [30:0]      mem_addr,
    input  logic [31:0]      mem_data
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_t             state;
    logic [30:0]        addr;
    logic [LEN_W-1:0]   rem;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               debug_win;
    logic               oor;

    // Debug takes the port when fetch is idle or it has been denied long enough.
    assign debug_win = (state == READ) && (!f_req || (wait_cnt == WAIT_W'(MAX_WAIT)));
    assign oor       = idx_oor(addr, ROM_SIZE);

    assign mem_addr  = debug_win ? addr : f_addr;
    assign f_data    = (f_req && !debug_win) ? mem_data : 32'h0;
    assign f_stall   = f_req && debug_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            wait_cnt <= '0;
            d_data   <= '0;
            d_valid  <= 1'b0;
            d_done   <= 1'b0;
            d_busy   <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_start) begin
                        d_err  <= 1'b0;
                        d_busy <= 1'b1;
                        if (d_len != '0) begin
                            state    <= READ;
                            addr     <= d_base;
                            rem      <= d_len;
                            wait_cnt <= '0;
                        end else begin
                            state  <= DONE;
                            d_done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (debug_win) begin
                        d_data   <= oor ? 32'h0 : mem_data;
                        if (oor)
                            d_err <= 1'b1;
                        d_valid  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= HOLD;
                    end else begin
                        // Cannot exceed MAX_WAIT: reaching it forces a win.
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (d_ready) begin
                        d_valid <= 1'b0;
                        addr    <= addr + 31'd4;
                        rem     <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state  <= DONE;
                            d_done <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    d_done <= 1'b0;
                    d_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_dump_arbiter.md
# imem_dump_arbiter

Shares the single combinational instruction-ROM read port between the CPU fetch path and a debug burst reader, which streams ROM words out over a valid/ready link to the UART TX side. Fetch has priority. A starvation counter guarantees the debug reader one slot after a bounded wait, and it takes that slot by stalling the CPU for one cycle. The block sits between the CPU's IF stage and the ROM.

## Interface
- ROM_SIZE, 256, ROM depth in words; word index = addr[30:2]
- MAX_WAIT, 4, consecutive denied debug cycles before a forced steal
- LEN_W, 8, width of the burst length field
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- f_req  in  1  CPU fetch request this cycle
- f_addr  in  31  CPU fetch byte address
- f_data  out  32  instruction to CPU (combinational)
- f_stall  out  1  CPU must hold PC this cycle
- d_start  in  1  one-cycle pulse: begin burst
- d_base  in  31  burst start byte address, sampled on d_start
- d_len  in  LEN_W  burst length in words, sampled on d_start
- d_busy  out  1  burst in progress
- d_data  out  32  registered ROM word
- d_valid  out  1  d_data valid
- d_ready  in  1  consumer accepts d_data
- d_done  out  1  one-cycle pulse at burst end
- d_err  out  1  sticky: burst touched word index >= ROM_SIZE
- mem_addr  out  31  ROM address
- mem_data  in  32  ROM data (combinational)

## Operation
- FSM states:
  - IDLE → READ on d_start with d_len≠0. Latches addr = d_base, rem = d_len, wait_cnt = 0, d_err = 0.
  - IDLE → DONE on d_start with d_len = 0.
- READ: debug wins the port when f_req=0 or wait_cnt==MAX_WAIT.
  - On a win: d_data ← mem_data, or 0 when addr[30:2] >= ROM_SIZE (which also sets d_err). d_valid ← 1, wait_cnt ← 0, go to HOLD.
  - On a loss: wait_cnt++.
- HOLD: d_valid held with d_data stable until d_ready.
  - On accept: d_valid ← 0, addr += 4, rem--.
  - If rem was 1, go to DONE; else go to READ.
- DONE: d_done=1 for exactly one cycle, then IDLE.
- d_busy=1 in READ, HOLD and DONE. d_start is ignored when not IDLE.
- Port mux:
  - mem_addr = addr when debug wins, else f_addr.
  - f_data = mem_data when fetch is served, else 32'h0.
  - f_stall = f_req & debug_win.
- Addresses wrap modulo 2^31. The wrapped word is read normally and the range check still applies.
- Reset (any state, mid-burst included) returns to IDLE. All registered outputs clear: d_data=0, d_valid=0, d_done=0, d_busy=0, d_err=0. Internal addr, rem and wait_cnt also clear to 0.

## Timing
- Fetch path is zero-latency combinational. A stall costs the CPU exactly one cycle per debug word, and only when f_req=1.
- A debug win in cycle N gives d_valid=1 in cycle N+1.
- With f_req held high, debug wins on its (MAX_WAIT+1)th READ cycle.
- If d_ready is already high when d_valid rises, the handshake completes that cycle, and the next READ begins the following cycle.
- Maximum throughput with f_req=0 is one word per 2 cycles (READ, HOLD).
- d_done rises one cycle after the final handshake. For d_len=0 it rises one cycle after d_start.
- d_err updates in the same cycle d_data is captured and stays set until the next accepted d_start.

## Structure
- Shared package `imem_pkg`:
  - ROM_SIZE default
  - state enum {IDLE, READ, HOLD, DONE}
  - helper for the word-index range check
- No sub-module is required.
- Optional sub-module `starve_counter` (saturating wait counter with clear), reusable for the data-memory arbiter.

## Test plan
- f_req=0, d_start with d_base=0, d_len=3, d_ready=1 → d_data sequence 08000003, 08000070, 0800009a at one word per 2 cycles; d_done one cycle after the third accept; f_stall never asserted.
- f_req=1 continuously, d_len=2 → each debug win lands on the 5th READ cycle; f_stall pulses exactly once per word; f_data=0 during the stall cycle and otherwise equals the ROM word at f_addr.
- d_base=0x3FC, d_len=2, ROM_SIZE=256 → first word = ROM[255], second word = 0 with d_err=1 (index 256 is out of range).
- d_ready held low 10 cycles in HOLD → d_valid and d_data stable throughout, no further ROM steal, no address advance.
- d_len=0 → d_done one cycle after d_start, no d_valid; a second d_start during a live burst is ignored.
- reset deasserted for a mid-burst (HOLD, d_valid=1) then reasserted → all outputs 0 asynchronously; a fresh d_start restarts from the new d_base.
